// File: rtl/frame_plotter.sv
// frame_plotter: scans a 16x32 bitmap and emits one VGA plot write per cycle.
// The full-frame scan order is column-major: y is the fast index, x the slow one.
// In diff mode, only pixels that differ from the previously completed frame are
// strobed. The scan always takes the same number of cycles whatever it plots.
//
// Timeline per frame (edge N accepts start):
//   N          : frame/diff_mode snapshotted, pixel 0 issued, busy rises
//   N+1..N+511 : pixels 1..511 issued
//   N+512      : done pulse, drawn_count updated
//   N+513      : back to IDLE, busy falls
//   N+514      : earliest next accept (514-cycle period with start held high)
module frame_plotter #(
  parameter logic [2:0] FG_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         start,
  input  logic [511:0] frame,
  input  logic         diff_mode,
  output logic [3:0]   x,
  output logic [4:0]   y,
  output logic [2:0]   colour,
  output logic         plot,
  output logic         busy,
  output logic         done,
  output logic [9:0]   drawn_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e       state_q;
  // Address of the next pixel to issue in SCAN; a wrap back to 0 marks scan end.
  logic [8:0]   addr_q;
  logic [511:0] snap_q;
  logic [511:0] prev_q;
  logic         diff_q;
  logic         prev_valid_q;
  logic [9:0]   cnt_q;

  logic         accept;
  logic         issue;
  logic [8:0]   issue_addr;
  logic         issue_bit;
  logic         issue_diff;
  logic         plot_d;
  logic [9:0]   cnt_d;

  // Saturating increment for the per-frame plot counter.
  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    if (v == 10'd512) begin
      return v;
    end else begin
      return v + 10'd1;
    end
  endfunction

  // Select the pixel being issued this cycle and decide whether it is strobed.
  always_comb begin
    accept     = 1'b0;
    issue      = 1'b0;
    issue_addr = 9'd0;
    issue_bit  = 1'b0;
    issue_diff = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Pixel 0 is taken straight from the input on the accepting edge.
        accept     = start;
        issue      = start;
        issue_addr = 9'd0;
        issue_bit  = frame[0];
        issue_diff = diff_mode;
      end
      S_SCAN: begin
        issue      = (addr_q != 9'd0);
        issue_addr = addr_q;
        issue_bit  = snap_q[addr_q];
        issue_diff = diff_q;
      end
      default: begin
        issue = 1'b0;
      end
    endcase
    plot_d = issue & (~issue_diff | ~prev_valid_q | (issue_bit ^ prev_q[issue_addr]));
    if (plot_d) begin
      cnt_d = (state_q == S_IDLE) ? 10'd1 : sat_inc(cnt_q);
    end else begin
      cnt_d = (state_q == S_IDLE) ? 10'd0 : cnt_q;
    end
  end

  // Frame snapshot and previous-frame memory; contents are don't-care after reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      snap_q <= frame;
    end
    if (issue) begin
      prev_q[issue_addr] <= issue_bit;
    end
  end

  // Control FSM with registered plot-port outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      addr_q       <= 9'd0;
      diff_q       <= 1'b0;
      prev_valid_q <= 1'b0;
      cnt_q        <= 10'd0;
      x            <= 4'd0;
      y            <= 5'd0;
      colour       <= BG_COLOUR;
      plot         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      drawn_count  <= 10'd0;
    end else begin
      plot <= plot_d;
      if (plot_d) begin
        x      <= issue_addr[8:5];
        y      <= issue_addr[4:0];
        colour <= issue_bit ? FG_COLOUR : BG_COLOUR;
      end
      case (state_q)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_q <= S_SCAN;
            diff_q  <= diff_mode;
            addr_q  <= 9'd1;
            cnt_q   <= cnt_d;
            busy    <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        S_SCAN: begin
          if (addr_q == 9'd0) begin
            state_q      <= S_DONE;
            done         <= 1'b1;
            drawn_count  <= cnt_q;
            prev_valid_q <= 1'b1;
          end else begin
            addr_q <= addr_q + 9'd1;
            cnt_q  <= cnt_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_plotter.sv
// Self-checking bench for frame_plotter: a timeline-based reference model is
// compared with the DUT on every falling edge, plus directed literal checks.
module tb_frame_plotter;

  localparam logic [2:0] FG = 3'b111;
  localparam logic [2:0] BG = 3'b000;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic [511:0] frame = '0;
  logic         diff_mode = 1'b0;
  logic [3:0]   x;
  logic [4:0]   y;
  logic [2:0]   colour;
  logic         plot;
  logic         busy;
  logic         done;
  logic [9:0]   drawn_count;

  always #5 clock = ~clock;

  frame_plotter #(.FG_COLOUR(FG), .BG_COLOUR(BG)) dut (
    .clock(clock), .resetn(resetn), .start(start), .frame(frame),
    .diff_mode(diff_mode), .x(x), .y(y), .colour(colour), .plot(plot),
    .busy(busy), .done(done), .drawn_count(drawn_count)
  );

  int pass_n = 0;
  int total_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // m_k = edges since the accepting edge (0 = accept); -1 when never started.
  int           m_k = -1;
  int           m_cnt = 0;
  logic [511:0] m_snap = '0;
  logic [511:0] m_prev = '0;
  logic         m_diff = 1'b0;
  logic         m_pv = 1'b0;
  logic [3:0]   m_x = 4'd0;
  logic [4:0]   m_y = 5'd0;
  logic [2:0]   m_col = BG;
  logic         m_plot = 1'b0;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [9:0]   m_dc = 10'd0;

  task automatic emit(input int a);
    logic b;
    logic p;
    b = m_snap[a];
    p = !m_diff || !m_pv || (b != m_prev[a]);
    m_prev[a] = b;
    m_plot = p;
    if (p) begin
      m_x = 4'(a / 32);
      m_y = 5'(a % 32);
      m_col = b ? FG : BG;
      m_cnt++;
    end
  endtask

  initial begin
    forever begin
      @(posedge clock or negedge resetn);
      if (!resetn) begin
        m_k = -1; m_x = 4'd0; m_y = 5'd0; m_col = BG; m_plot = 1'b0;
        m_busy = 1'b0; m_done = 1'b0; m_dc = 10'd0; m_pv = 1'b0;
      end else if (m_k < 0 || m_k >= 513) begin
        if (start) begin
          m_k = 0; m_snap = frame; m_diff = diff_mode; m_cnt = 0;
          m_busy = 1'b1; m_done = 1'b0;
          emit(0);
        end else begin
          m_k = -1; m_plot = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        end
      end else begin
        m_k++;
        if (m_k <= 511) emit(m_k);
        else if (m_k == 512) begin
          m_plot = 1'b0; m_done = 1'b1; m_dc = 10'(m_cnt); m_pv = 1'b1;
        end else begin
          m_plot = 1'b0; m_done = 1'b0; m_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- compare + plot logger ----------------
  int         cyc = 0;
  int         plot_n = 0;
  int         done_n = 0;
  logic [3:0] lx [512];
  logic [4:0] ly [512];
  logic [2:0] lc [512];

  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      check("cycle", {7'd0, x, y, colour, plot, busy, done, drawn_count},
            {7'd0, m_x, m_y, m_col, m_plot, m_busy, m_done, m_dc});
      if (plot === 1'b1) begin
        if (plot_n < 512) begin
          lx[plot_n] = x; ly[plot_n] = y; lc[plot_n] = colour;
        end
        plot_n++;
      end
      if (done === 1'b1) done_n++;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [511:0] rnd_frame();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Pulse start for one edge, return edges from accept (1) to done (513).
  task automatic run_frame(input logic [511:0] f, input logic d, output int edges);
    frame = f; diff_mode = d; start = 1'b1;
    @(posedge clock); edges = 1; #1 start = 1'b0;
    while (edges < 600) begin
      @(negedge clock);
      if (done) break;
      @(posedge clock);
      edges++;
    end
    @(posedge clock); @(posedge clock); #1;
  endtask

  logic [511:0] f1, f2, fr;
  int e, err, w, t1, t2, low;

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_x", 32'(x), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_colour", 32'(colour), 32'(BG));
    check("rst_flags", {29'd0, plot, busy, done}, 32'd0);
    check("rst_count", 32'(drawn_count), 32'd0);
    resetn = 1'b1;
    @(posedge clock); #1;

    // All ones, full draw.
    plot_n = 0;
    run_frame({512{1'b1}}, 1'b0, e);
    check("full_done_edge", e, 513);
    check("full_plots", plot_n, 512);
    check("full_count", 32'(drawn_count), 32'd512);
    err = 0;
    for (int i = 0; i < 512; i++)
      if (lx[i] !== 4'(i / 32) || ly[i] !== 5'(i % 32) || lc[i] !== 3'b111) err++;
    check("full_order", err, 0);

    // Same frame in diff mode: nothing to draw.
    plot_n = 0;
    run_frame({512{1'b1}}, 1'b1, e);
    check("diff_same_done_edge", e, 513);
    check("diff_same_plots", plot_n, 0);
    check("diff_same_count", 32'(drawn_count), 32'd0);

    // Corner bits cleared.
    fr = {512{1'b1}}; fr[0] = 1'b0; fr[511] = 1'b0;
    plot_n = 0;
    run_frame(fr, 1'b1, e);
    check("corner_plots", plot_n, 2);
    check("corner_count", 32'(drawn_count), 32'd2);
    check("corner_first", {20'd0, lx[0], ly[0], lc[0]}, {20'd0, 4'd0, 5'd0, 3'b000});
    check("corner_last", {20'd0, lx[1], ly[1], lc[1]}, {20'd0, 4'd15, 5'd31, 3'b000});

    // Start pulsed and frame changed mid-scan.
    f1 = rnd_frame(); f2 = rnd_frame();
    frame = f1; diff_mode = 1'b0; start = 1'b1;
    @(posedge clock); #1 start = 1'b0; done_n = 0;
    repeat (99) @(posedge clock);
    #1 start = 1'b1; frame = f2; diff_mode = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (520) @(posedge clock);
    #1;
    check("midscan_single_done", done_n, 1);

    // Reset in the middle of a scan, then a diff frame must redraw fully.
    run_frame(f2, 1'b0, e);
    frame = f2; diff_mode = 1'b1; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (300) @(posedge clock);
    #1 check("busy_before_reset", 32'(busy), 32'd1);
    #1 resetn = 1'b0;
    #1 check("async_clear", {7'd0, x, y, colour, plot, busy, done, drawn_count}, 32'd0);
    @(posedge clock); #1 resetn = 1'b1;
    plot_n = 0;
    run_frame(f2, 1'b1, e);
    check("post_reset_done_edge", e, 513);
    check("post_reset_plots", plot_n, 512);
    check("post_reset_count", 32'(drawn_count), 32'd512);

    // Start tied high: frame period and busy gap.
    frame = rnd_frame(); diff_mode = 1'b0; start = 1'b1;
    w = 0;
    while (w < 700) begin @(negedge clock); if (done) break; w++; end
    t1 = cyc;
    low = 0; w = 0;
    while (w < 700) begin
      @(negedge clock); w++;
      if (done) break;
      if (!busy) low++;
    end
    t2 = cyc;
    start = 1'b0;
    check("period", t2 - t1, 514);
    check("busy_gap", low, 1);
    repeat (4) @(posedge clock);
    #1;

    // Randomized frames, checked cycle by cycle against the model.
    fr = rnd_frame();
    for (int r = 0; r < 6; r++) begin
      if (r % 2 == 1) begin
        for (int k = 0; k < 4; k++) begin
          int idx;
          idx = $urandom_range(0, 511);
          fr[idx] = ~fr[idx];
        end
      end else begin
        fr = rnd_frame();
      end
      run_frame(fr, 1'($urandom % 2), e);
      check("rand_done_edge", e, 513);
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
    end

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
